arbiter_req_agent: RTL and testbench

ARBITER_REQ_AGENT -- requirements
Module: arbiter_req_agent

---
 rtl/arbiter_req_agent.sv | 88 ++++++++
 tb/tb_arbiter_req_agent.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_req_agent.sv
// Request-side agent for one client of a fixed-priority arbiter: queues payloads,
// raises a request while non-empty, and tracks grant starvation and stray grants.
module arbiter_req_agent #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_wr_valid,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    output logic                              o_wr_ready,
    output logic                              o_req,
    input  logic                              i_grant,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] o_wait_cnt,
    output logic                              o_starve,
    output logic                              o_grant_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [WW-1:0]         wait_cnt;
    logic [WW-1:0]         wait_next;
    logic                  grant_err;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Request and ready come only from registered pointers, so i_grant never
    // loops back into o_req or o_wr_ready within the same cycle.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = i_wr_valid && !full;
    assign pop   = !empty && i_grant;

    assign o_wr_ready  = !full;
    assign o_req       = !empty;
    assign o_data      = mem[rd_ptr[AW-1:0]];
    assign o_count     = wr_ptr - rd_ptr;
    assign o_wait_cnt  = wait_cnt;
    assign o_starve    = (wait_cnt == LIMIT);
    assign o_grant_err = grant_err;

    always_comb begin
        wait_next = wait_cnt;
        if (pop || empty) begin
            wait_next = '0;
        end else if (wait_cnt != LIMIT) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wait_cnt  <= '0;
            grant_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            wait_cnt <= wait_next;
            if (i_grant && empty) begin
                grant_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; emptiness is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_arbiter_req_agent.sv
// Self-checking bench for arbiter_req_agent: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_arbiter_req_agent;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 15;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WW    = $clog2(LIMIT + 1);
    localparam int SW    = 1 + 1 + CW + WW + 1 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          req;
    logic          grant = 1'b0;
    logic [DW-1:0] data;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic          starve;
    logic          grant_err;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_q [$];
    int            m_wait = 0;
    bit            m_err  = 1'b0;

    arbiter_req_agent #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_req(req), .i_grant(grant), .o_data(data),
        .o_count(count), .o_wait_cnt(wait_cnt), .o_starve(starve),
        .o_grant_err(grant_err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] exp_status();
        int n;
        n = m_q.size();
        return {n != 0, n < DEPTH, CW'(n), WW'(m_wait), m_wait == LIMIT, m_err};
    endfunction

    function automatic logic [SW-1:0] act_status();
        return {req, wr_ready, count, wait_cnt, starve, grant_err};
    endfunction

    // One clock: drive inputs, advance the model on the edge, settle just after it.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic g);
        bit m_req;
        bit m_pop;
        bit m_push;
        wr_valid = v;
        wr_data  = d;
        grant    = g;
        @(posedge clk);
        m_req  = m_q.size() != 0;
        m_pop  = m_req && g;
        m_push = v && (m_q.size() < DEPTH);
        if (m_pop) void'(m_q.pop_front());
        if (m_push) m_q.push_back(d);
        if (g && !m_req) m_err = 1'b1;
        if (m_pop || !m_req) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wait = 0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (act_status() !== exp_status()) begin
            n_err++;
            $display("[TB] FAIL reset_state: got %b expected %b", act_status(), exp_status());
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        cycle(1'b1, 8'hA5, 1'b0);
        n_vec++;
        if (req !== 1'b1 || data !== 8'hA5 || count !== CW'(1)) begin
            n_err++;
            $display("[TB] FAIL single_push: got req=%b data=%h count=%0d expected req=1 data=a5 count=1", req, data, count);
        end
        cycle(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (req !== 1'b0 || count !== CW'(0)) begin
            n_err++;
            $display("[TB] FAIL single_pop: got req=%b count=%0d expected req=0 count=0", req, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
        n_vec++;
        if (count !== CW'(4) || wr_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL fill_full: got count=%0d ready=%b expected count=4 ready=0", count, wr_ready);
        end
        cycle(1'b1, 8'h05, 1'b0);
        n_vec++;
        if (count !== CW'(4)) begin
            n_err++;
            $display("[TB] FAIL fill_reject: got count=%0d expected 4", count);
        end
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (req !== 1'b1 || data !== DW'(i)) begin
                n_err++;
                $display("[TB] FAIL fill_order: got req=%b data=%h expected req=1 data=%h", req, data, DW'(i));
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        n_vec++;
        if (act_status() !== exp_status() || count !== CW'(0)) begin
            n_err++;
            $display("[TB] FAIL fill_drain: got %b expected %b", act_status(), exp_status());
        end
    endtask

    task automatic test_starve();
        cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (act_status() !== exp_status()) begin
                n_err++;
                $display("[TB] FAIL starve_cycle%0d: got %b expected %b", i, act_status(), exp_status());
            end
        end
        n_vec++;
        if (wait_cnt !== WW'(LIMIT) || starve !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL starve_sat: got wait=%0d starve=%b expected wait=15 starve=1", wait_cnt, starve);
        end
        cycle(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (wait_cnt !== '0 || starve !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL starve_clear: got wait=%0d starve=%b expected wait=0 starve=0", wait_cnt, starve);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
            n_vec++;
            if (count !== CW'(2) || data !== m_q[0] || act_status() !== exp_status()) begin
                n_err++;
                $display("[TB] FAIL b2b_xfer%0d: got count=%0d data=%h status=%b expected count=2 data=%h status=%b",
                         i, count, data, act_status(), m_q[0], exp_status());
            end
        end
        while (m_q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_grant_err();
        cycle(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (grant_err !== 1'b1 || count !== CW'(0)) begin
            n_err++;
            $display("[TB] FAIL grant_err_set: got err=%b count=%0d expected err=1 count=0", grant_err, count);
        end
        repeat (3) cycle(1'b1, 8'h77, 1'b0);
        n_vec++;
        if (grant_err !== 1'b1 || act_status() !== exp_status()) begin
            n_err++;
            $display("[TB] FAIL grant_err_sticky: got %b expected %b", act_status(), exp_status());
        end
    endtask

    task automatic test_async_reset();
        n_vec++;
        if (count !== CW'(3)) begin
            n_err++;
            $display("[TB] FAIL areset_pre: got count=%0d expected 3", count);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (req !== 1'b0 || count !== CW'(0) || wr_ready !== 1'b1 || grant_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL areset_async: got req=%b count=%0d ready=%b err=%b expected req=0 count=0 ready=1 err=0",
                     req, count, wr_ready, grant_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 8'h9E, 1'b0);
        n_vec++;
        if (req !== 1'b1 || data !== 8'h9E || count !== CW'(1)) begin
            n_err++;
            $display("[TB] FAIL areset_first_push: got req=%b data=%h count=%0d expected req=1 data=9e count=1", req, data, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 35));
            n_vec++;
            if (act_status() !== exp_status() || (m_q.size() != 0 && data !== m_q[0])) begin
                n_err++;
                $display("[TB] FAIL random%0d: got status=%b data=%h expected status=%b data=%h",
                         i, act_status(), data, exp_status(), (m_q.size() != 0) ? m_q[0] : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_starve();
        test_back_to_back();
        test_grant_err();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
